// File: rtl/studio2_pkg.sv
// studio2_pkg: shared types and memory-map constants for the Studio II memory arbiter.
//   arb_state_e : arbiter state (idle / loader / CPU access / DMA burst)
//   region_e    : decoded address region
//   owner_e     : tag recording which requester an issued read belongs to
//   *Base       : region base offsets within the 4 KB map (offset = addr[11:0])
//   OpenBus     : value returned for reads that hit no memory
package studio2_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StCpu, StDma} arb_state_e;

    typedef enum logic [2:0] {
        RegRom, RegCart, RegRam, RegVram, RegMirror, RegMcart, RegUnmapped
    } region_e;

    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

    localparam logic [11:0] RomBase    = 12'h000;
    localparam logic [11:0] CartBase   = 12'h400;
    localparam logic [11:0] RamBase    = 12'h800;
    localparam logic [11:0] VramBase   = 12'h900;
    localparam logic [11:0] McartABase = 12'hA00;
    localparam logic [11:0] MirrorBase = 12'hC00;
    localparam logic [11:0] McartBBase = 12'hE00;
    localparam logic [11:0] MapLimit   = 12'hFFF;

    // Clearing this bit folds the 0xC00-0xDFF mirror onto RAM at 0x800-0x9FF.
    localparam logic [11:0] MirrorBit  = 12'h400;

    localparam logic [7:0]  OpenBus    = 8'hFF;

endpackage

// File: rtl/studio2_addr_decode.sv
// studio2_addr_decode: combinational Studio II memory-map decode.
// Build option: STUDIO2_MULTICART_EN maps 0xA00-0xBFF and 0xE00-0xFFF as cart ROM;
// without it those ranges are unmapped.
// Ports:
//   addr     in  16  requester address
//   region   out     decoded region (RegUnmapped when addr[15:12] != 0)
//   maddr    out AW  physical memory address (mirror folded onto RAM)
//   writable out 1   region accepts CPU writes
module studio2_addr_decode
    import studio2_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic [15:0]   addr,
    output region_e       region,
    output logic [AW-1:0] maddr,
    output logic          writable
);

`ifdef STUDIO2_MULTICART_EN
    localparam region_e OptRegion = RegMcart;
`else
    localparam region_e OptRegion = RegUnmapped;
`endif

    logic [11:0] off;
    assign off = addr[11:0];

    always_comb begin
        region = RegUnmapped;
        if (addr[15:12] == 4'h0) begin
            if (off < CartBase)        region = RegRom;
            else if (off < RamBase)    region = RegCart;
            else if (off < VramBase)   region = RegRam;
            else if (off < McartABase) region = RegVram;
            else if (off < MirrorBase) region = OptRegion;
            else if (off < McartBBase) region = RegMirror;
            else                       region = OptRegion;
        end
    end

    always_comb begin
        maddr = AW'(off);
        if (region == RegMirror) maddr = AW'(off & ~MirrorBit);
    end

    assign writable = (region == RegRam) || (region == RegVram) || (region == RegMirror);

endmodule

// File: rtl/studio2_bus_arbiter.sv
// studio2_bus_arbiter: single-port arbiter for the Studio II 4 KB system memory.
// Priority loader > DMA (locked bursts of DMA_BURST beats) > CPU, with a fairness flag
// giving the CPU the slot right after a burst it waited through. All grants and memory
// strobes are registered (request in N -> access in N+1 -> rvalid/dout in N+2).
// Build option: STUDIO2_MULTICART_EN (see studio2_addr_decode).
// Ports:
//   clk, reset                      clock, async active-high reset
//   ldr_active/wr/addr/din          cartridge/BIOS loader (owns memory while active)
//   cpu_req/wr/addr/din             CPU request, held until cpu_gnt
//   cpu_gnt/rvalid/dout             CPU grant pulse, read-data valid pulse, read data
//   dma_req/addr                    display fetch request, held for the burst
//   dma_gnt/last/rvalid/dout        DMA beat grant, last-beat flag, read valid, read data
//   mem_ce/wr/addr/din, mem_dout    dpram A port (1-cycle read latency)
//   wp_violation                    pulse: CPU write to protected space dropped
module studio2_bus_arbiter
    import studio2_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter int unsigned DMA_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ldr_active,
    input  logic          ldr_wr,
    input  logic [AW-1:0] ldr_addr,
    input  logic [7:0]    ldr_din,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [15:0]   cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_dout,
    input  logic          dma_req,
    input  logic [15:0]   dma_addr,
    output logic          dma_gnt,
    output logic          dma_last,
    output logic          dma_rvalid,
    output logic [7:0]    dma_dout,
    output logic          mem_ce,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          wp_violation
);

    localparam int unsigned BW = 4;  // covers DMA_BURST up to 16
    localparam logic [BW-1:0] LastBeat = BW'(DMA_BURST - 1);

    region_e       cpu_region, dma_region;
    logic [AW-1:0] cpu_maddr, dma_maddr;
    logic          cpu_writable, dma_writable;
    logic          cpu_mapped, dma_mapped;

    studio2_addr_decode #(.AW(AW)) u_cpu_decode (
        .addr     (cpu_addr),
        .region   (cpu_region),
        .maddr    (cpu_maddr),
        .writable (cpu_writable)
    );

    studio2_addr_decode #(.AW(AW)) u_dma_decode (
        .addr     (dma_addr),
        .region   (dma_region),
        .maddr    (dma_maddr),
        .writable (dma_writable)
    );

    // DMA is read-only, so its writable flag is not needed.
    logic unused_dma_writable;
    assign unused_dma_writable = dma_writable;

    assign cpu_mapped = (cpu_region != RegUnmapped);
    assign dma_mapped = (dma_region != RegUnmapped);

    arb_state_e    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          cpu_owed_q, cpu_owed_d;
    owner_e        owner_q, owner_d;
    logic          open_q, open_d;    // issued read hits no memory
    logic          ret_open_q;        // open_q aligned with rvalid
    logic          mem_ce_d, mem_wr_d, cpu_gnt_d, dma_gnt_d, dma_last_d, wp_d;
    logic [AW-1:0] mem_addr_d;
    logic [7:0]    mem_din_d;
    logic          grant_cpu, grant_dma, in_burst;

    assign in_burst = (state_q == StDma) && (beat_q != '0);

    always_comb begin
        state_d    = StIdle;
        beat_d     = beat_q;
        cpu_owed_d = cpu_owed_q;
        owner_d    = OwnNone;
        open_d     = 1'b0;
        mem_ce_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_addr_d = '0;
        mem_din_d  = '0;
        cpu_gnt_d  = 1'b0;
        dma_gnt_d  = 1'b0;
        dma_last_d = 1'b0;
        wp_d       = 1'b0;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;

        if (ldr_active) begin
            // Loader aborts any burst; pending requests simply wait.
            state_d    = StLoad;
            beat_d     = '0;
            mem_ce_d   = ldr_wr;
            mem_wr_d   = ldr_wr;
            mem_addr_d = ldr_addr;
            mem_din_d  = ldr_din;
        end else begin
            if (in_burst && dma_req)      grant_dma = 1'b1;
            else if (cpu_owed_q && cpu_req) grant_cpu = 1'b1;
            else if (dma_req)             grant_dma = 1'b1;
            else if (cpu_req)             grant_cpu = 1'b1;

            // Request dropped mid-burst: burst is over.
            if (in_burst && !dma_req) beat_d = '0;

            if (grant_dma) begin
                state_d    = StDma;
                dma_gnt_d  = 1'b1;
                owner_d    = OwnDma;
                mem_ce_d   = dma_mapped;
                mem_addr_d = dma_maddr;
                open_d     = !dma_mapped;
                if (beat_q == LastBeat) begin
                    dma_last_d = 1'b1;
                    beat_d     = '0;
                    if (cpu_req) cpu_owed_d = 1'b1;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            if (grant_cpu) begin
                state_d    = StCpu;
                cpu_gnt_d  = 1'b1;
                cpu_owed_d = 1'b0;
                if (cpu_wr) begin
                    if (cpu_writable) begin
                        mem_ce_d   = 1'b1;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = cpu_maddr;
                        mem_din_d  = cpu_din;
                    end else begin
                        // Unmapped writes vanish silently; only protected space flags.
                        wp_d = cpu_mapped;
                    end
                end else begin
                    owner_d    = OwnCpu;
                    mem_ce_d   = cpu_mapped;
                    mem_addr_d = cpu_maddr;
                    open_d     = !cpu_mapped;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            cpu_owed_q   <= 1'b0;
            owner_q      <= OwnNone;
            open_q       <= 1'b0;
            mem_ce       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            cpu_gnt      <= 1'b0;
            dma_gnt      <= 1'b0;
            dma_last     <= 1'b0;
            wp_violation <= 1'b0;
            cpu_rvalid   <= 1'b0;
            dma_rvalid   <= 1'b0;
            ret_open_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cpu_owed_q   <= cpu_owed_d;
            owner_q      <= owner_d;
            open_q       <= open_d;
            mem_ce       <= mem_ce_d;
            mem_wr       <= mem_wr_d;
            mem_addr     <= mem_addr_d;
            mem_din      <= mem_din_d;
            cpu_gnt      <= cpu_gnt_d;
            dma_gnt      <= dma_gnt_d;
            dma_last     <= dma_last_d;
            wp_violation <= wp_d;
            cpu_rvalid   <= (owner_q == OwnCpu);
            dma_rvalid   <= (owner_q == OwnDma);
            ret_open_q   <= open_q;
        end
    end

    // dpram data arrives in the rvalid cycle; gating keeps dout at 0 outside rvalid.
    logic [7:0] rdata;
    assign rdata    = ret_open_q ? OpenBus : mem_dout;
    assign cpu_dout = cpu_rvalid ? rdata : 8'h00;
    assign dma_dout = dma_rvalid ? rdata : 8'h00;

endmodule

// File: tb/tb_studio2_bus_arbiter.sv
// tb_studio2_bus_arbiter: directed self-checking bench for studio2_bus_arbiter
// (AW=12, DMA_BURST=8) with a behavioural dpram on the A port.
module tb_studio2_bus_arbiter;

    localparam int unsigned AW = 12;
`ifdef STUDIO2_MULTICART_EN
    localparam logic MC = 1'b1;
`else
    localparam logic MC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ldr_active, ldr_wr;
    logic [AW-1:0] ldr_addr;
    logic [7:0]    ldr_din;
    logic          cpu_req, cpu_wr;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_gnt, cpu_rvalid;
    logic [7:0]    cpu_dout;
    logic          dma_req;
    logic [15:0]   dma_addr;
    logic          dma_gnt, dma_last, dma_rvalid;
    logic [7:0]    dma_dout;
    logic          mem_ce, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout = 8'h00;
    logic          wp_violation;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ram [4096];

    studio2_bus_arbiter #(.AW(AW), .DMA_BURST(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ldr_active   (ldr_active),
        .ldr_wr       (ldr_wr),
        .ldr_addr     (ldr_addr),
        .ldr_din      (ldr_din),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_dout     (cpu_dout),
        .dma_req      (dma_req),
        .dma_addr     (dma_addr),
        .dma_gnt      (dma_gnt),
        .dma_last     (dma_last),
        .dma_rvalid   (dma_rvalid),
        .dma_dout     (dma_dout),
        .mem_ce       (mem_ce),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .wp_violation (wp_violation)
    );

    always #5 clk = ~clk;

    // dpram A port: synchronous, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wr) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ldr_write(input logic [11:0] a, input logic [7:0] d);
        ldr_wr = 1'b1; ldr_addr = a; ldr_din = d;
        tick();
        check("ldr_write", {mem_ce, mem_wr, cpu_gnt, mem_addr, mem_din},
              {1'b1, 1'b1, 1'b0, a, d});
        ldr_wr = 1'b0;
    endtask

    task automatic cpu_access(input string tag, input logic wr, input logic [15:0] a,
                              input logic [7:0] d, input logic exp_ce, input logic exp_wr,
                              input logic [11:0] exp_maddr, input logic exp_wp,
                              input logic exp_rv, input logic [7:0] exp_dout);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
        tick();
        check({tag, "_issue"}, {cpu_gnt, mem_ce, mem_wr, wp_violation},
              {1'b1, exp_ce, exp_wr, exp_wp});
        if (exp_ce) check({tag, "_maddr"}, mem_addr, exp_maddr);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        tick();
        check({tag, "_resp"}, {cpu_rvalid, cpu_gnt, wp_violation}, {exp_rv, 1'b0, 1'b0});
        if (exp_rv) check({tag, "_dout"}, cpu_dout, exp_dout);
    endtask

    task automatic dma_run(input string tag, input int beats);
        for (int k = 0; k < beats; k++) begin
            tick();
            check(tag, {dma_gnt, dma_last, cpu_gnt}, {1'b1, k == 7, 1'b0});
        end
    endtask

    initial begin
        logic [11:0] exp_a;
        reset = 1'b1;
        ldr_active = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_din = 8'h00;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
        dma_req = 1'b0; dma_addr = 16'h0000;
        #2;
        check("reset_strobes", {mem_ce, mem_wr, cpu_gnt, cpu_rvalid, dma_gnt, dma_last,
                                dma_rvalid, wp_violation}, 8'h00);
        check("reset_data", {cpu_dout, dma_dout, mem_din, mem_addr}, 36'h0);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b0;
        tick();

        // Loader owns memory while a CPU read of the mirror waits.
        ldr_active = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0C05;
        ldr_write(12'h805, 8'h5A);
        ldr_write(12'h400, 8'hD1);
        ldr_write(12'h401, 8'h0E);
        ldr_write(12'h123, 8'h33);
        ldr_write(12'h901, 8'h3C);
        ldr_write(12'hA10, 8'h6B);
        tick();
        check("ldr_idle_hold", {mem_ce, cpu_gnt}, 2'b00);
        ldr_active = 1'b0;
        tick();
        check("mirror_issue", {cpu_gnt, mem_ce, mem_wr, mem_addr}, {1'b1, 1'b1, 1'b0, 12'h805});
        cpu_req = 1'b0;
        tick();
        check("mirror_resp", {cpu_rvalid, cpu_dout}, {1'b1, 8'h5A});

        cpu_access("rom_wr", 1'b1, 16'h0123, 8'h77, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 8'h00);
        cpu_access("rom_rd", 1'b0, 16'h0123, 8'h00, 1'b1, 1'b0, 12'h123, 1'b0, 1'b1, 8'h33);
        cpu_access("ram_wr", 1'b1, 16'h0810, 8'hA5, 1'b1, 1'b1, 12'h810, 1'b0, 1'b0, 8'h00);
        cpu_access("mir_rd", 1'b0, 16'h0C10, 8'h00, 1'b1, 1'b0, 12'h810, 1'b0, 1'b1, 8'hA5);
        cpu_access("unm_rd", 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 8'hFF);
        cpu_access("unm_wr", 1'b1, 16'h1234, 8'h55, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00);
        cpu_access("mc_rd", 1'b0, 16'h0A10, 8'h00, MC, 1'b0, 12'hA10, 1'b0, 1'b1,
                   MC ? 8'h6B : 8'hFF);
        cpu_access("mc_wr", 1'b1, 16'h0E00, 8'h11, 1'b0, 1'b0, 12'h000, MC, 1'b0, 8'h00);

        // Locked burst from 0x900; CPU raises its request at beat 2 and must wait.
        dma_req = 1'b1; dma_addr = 16'h0900;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_a = 12'h900 + 12'(k);
            check("burst_beat", {dma_gnt, dma_last, cpu_gnt, mem_ce, mem_addr},
                  {1'b1, k == 7, 1'b0, 1'b1, exp_a});
            if (k == 2) begin
                check("burst_data", {dma_rvalid, dma_dout}, {1'b1, 8'h3C});
                cpu_req = 1'b1; cpu_addr = 16'h0400;
            end
            dma_addr = 16'h0900 + 16'(k + 1);
        end
        // dma_req stays high: the owed CPU slot still comes first.
        tick();
        check("owed_cpu", {cpu_gnt, dma_gnt, dma_rvalid}, 3'b101);
        cpu_req = 1'b0;
        tick();
        check("new_burst", {dma_gnt, dma_last, cpu_rvalid, cpu_dout}, {3'b101, 8'hD1});
        dma_req = 1'b0;
        tick();
        check("burst_drop", {dma_gnt, dma_rvalid, mem_ce}, 3'b010);

        // Same-cycle CPU and DMA from idle: DMA wins a full burst, then CPU.
        dma_req = 1'b1; dma_addr = 16'h0900;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0401;
        dma_run("dma_wins", 8);
        dma_req = 1'b0;
        tick();
        check("cpu_after", {cpu_gnt, dma_gnt}, 2'b10);
        cpu_req = 1'b0;
        tick();
        check("cpu_after_rd", {cpu_rvalid, cpu_dout}, {1'b1, 8'h0E});

        // Reset at beat 4 clears everything at once; the next burst restarts at beat 0.
        dma_req = 1'b1;
        dma_run("pre_reset", 5);
        #2 reset = 1'b1;
        #1;
        check("reset_async", {mem_ce, dma_gnt, dma_last, dma_rvalid, dma_dout, mem_addr},
              24'h0);
        @(posedge clk);
        #1;
        check("reset_no_rvalid", {dma_rvalid, dma_gnt}, 2'b00);
        #3 reset = 1'b0;
        dma_run("post_reset", 8);
        dma_req = 1'b0;
        tick();
        check("post_reset_end", {dma_gnt, dma_rvalid}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/studio2_bus_arbiter.md
# studio2_bus_arbiter

Arbitrates the Studio II's single 4 KB system memory between three requesters: the CDP1802 CPU, the CDP1861 display DMA fetch, and the ioctl cartridge/BIOS loader. It sits between those requesters and the dpram A port and issues at most one access per clock. It also applies the console memory map: region decode, mirroring of 0x0C00–0x0DFF, write protection of ROM/cart space and open-bus reads. DMA is served as locked line bursts.

## Interface
- `AW`, default 12: memory address width.
- `DMA_BURST`, default 8: bytes per display line burst (range 1–16).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `ldr_active`  in  1  download in progress; the loader owns memory while this is high.
- `ldr_wr`  in  1  loader write strobe.
- `ldr_addr`  in  AW  loader address (already offset by the caller).
- `ldr_din`  in  8  loader data.
- `cpu_req`  in  1  CPU access request. Held until `cpu_gnt`.
- `cpu_wr`  in  1  1 = write.
- `cpu_addr`  in  16  CPU address.
- `cpu_din`  in  8  CPU write data.
- `cpu_gnt`  out  1  one-cycle pulse: the access was issued.
- `cpu_rvalid`  out  1  read data valid pulse.
- `cpu_dout`  out  8  read data.
- `dma_req`  in  1  display fetch request. Held for the whole burst.
- `dma_addr`  in  16  fetch address.
- `dma_gnt`  out  1  per-beat grant pulse.
- `dma_last`  out  1  marks the final beat of a burst; coincides with `dma_gnt`.
- `dma_rvalid`  out  1  read data valid pulse.
- `dma_dout`  out  8  read data.
- `mem_ce`, `mem_wr`  out  1 each  dpram A-port strobes.
- `mem_addr`  out  AW  dpram address.
- `mem_din`  out  8  dpram write data.
- `mem_dout`  in  8  dpram read data (1-cycle latency).
- `wp_violation`  out  1  pulse: a CPU write to protected space was dropped.

## Operation
- **States:**
  - IDLE: no access this cycle.
  - LOAD: loader owns memory.
  - CPU: one CPU access.
  - DMA: a burst is in progress; a beat counter `beat` runs 0..DMA_BURST-1.
- **Priority:** loader, then DMA, then CPU.
  - Fairness flag `cpu_owed`: set when a burst ends while `cpu_req` is high.
  - While `cpu_owed` is set, the next slot goes to the CPU ahead of a new burst. It clears on that CPU grant.
- **LOAD:** entered whenever `ldr_active`=1.
  - Each `ldr_wr` produces one mem write with `ldr_addr`/`ldr_din`. The loader bypasses write protection.
  - No CPU or DMA grants are issued while in LOAD.
  - Leaving LOAD goes to IDLE.
- **DMA:**
  - Each cycle with `dma_req`=1 issues one beat and increments `beat`.
  - On `beat`=DMA_BURST-1, `dma_last` is asserted and the state returns to IDLE.
  - If `dma_req` drops mid-burst, the burst ends immediately and `beat` is reset to 0.
  - CPU requests wait during a burst.
- **CPU decode** (`cpu_addr[15:12]` ≠ 0 means unmapped):
  - 0x000–0x7FF (ROM/cart): reads pass through. Writes are dropped and `wp_violation` pulses; `cpu_gnt` is still issued.
  - 0x800–0x9FF: RAM/VRAM, read and write.
  - 0xC00–0xDFF: mirror of RAM; `mem_addr` = address with bit 10 cleared.
  - 0xA00–0xBFF and 0xE00–0xFFF: see Configuration.
  - Unmapped: no mem access; the read returns 0xFF; the write is dropped silently (no `wp_violation`).
- **DMA decode:** DMA uses the same decode, read-only.
- **Routing:** read data is routed to the requester that issued the access, using a registered owner tag.

## Timing
- Request sampled in cycle N → `mem_*` and gnt are registered and asserted in N+1 → `rvalid` and `dout` in N+2.
- Back-to-back grants are allowed; throughput is one access per cycle.
- Out-of-map reads keep the same latency: the `rvalid` is generated and 0xFF is driven in N+2.
- An access already issued when `ldr_active` rises still returns its `rvalid` in the following cycle.
- Requests that are pending but not yet granted are held off until LOAD exits.
- A CPU request and a DMA request raised in the same cycle from IDLE, with `cpu_owed`=0: DMA wins.
- **Reset (asynchronous, any time):**
  - State goes to IDLE; `beat`=0; `cpu_owed`=0; owner tag cleared.
  - All outputs go to 0, including `cpu_dout`/`dma_dout`.
  - In-flight `rvalid` pulses are suppressed.

## Configuration
- `STUDIO2_MULTICART_EN`:
  - Defined: 0xA00–0xBFF and 0xE00–0xFFF decode as cart ROM. Reads pass through; CPU writes are dropped with `wp_violation`.
  - Undefined: both ranges are treated as unmapped (read 0xFF, no mem access, no `wp_violation`).

## Structure
- **Package `studio2_pkg`:**
  - Arbiter state enum.
  - Region enum: ROM, CART, RAM, VRAM, MIRROR, MCART, UNMAPPED.
  - Memory map base/limit constants.
  - Open-bus value 0xFF.
- **Sub-module `studio2_addr_decode`:** combinational 16-bit address → {region, mapped AW address, writable}. Instantiated twice, once for CPU and once for DMA.

## Test plan
- CPU read 0x0C05 with RAM[0x805]=0x5A → `mem_addr`=0x805 in N+1; `cpu_rvalid` with `cpu_dout`=0x5A in N+2.
- CPU write 0x0123 ← 0x77 → `cpu_gnt`=1, `mem_wr`=0, `wp_violation`=1; RAM[0x123] unchanged.
- `dma_req` held from 0x0900 with DMA_BURST=8 and `cpu_req` raised at beat 2 → 8 consecutive DMA beats with `dma_last` on the 8th; `cpu_gnt` on the next cycle.
- `ldr_active`=1 with writes 0x400←0xD1 and 0x401←0x0E while `cpu_req`=1 → memory updated; no `cpu_gnt` until `ldr_active`=0.
- Without the macro: CPU read 0x0A10 → no `mem_ce`, `cpu_dout`=0xFF in N+2. With `STUDIO2_MULTICART_EN`: `mem_addr`=0xA10.
- Assert `reset` at DMA beat 4 → outputs 0 immediately, no `dma_rvalid`; after release, a new burst restarts at beat 0.
